// File: rtl/wm8731_dac_tx.sv
// rtl/wm8731_dac_tx.sv - WM8731 left-justified 16-bit stereo DAC serializer (bus master)
//
// Takes one stereo PCM pair per frame over a valid/ready handshake and drives
// the codec master clock, bit clock, LR clock and serial data.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high
//   sample_l/r    16-bit two's complement left/right sample
//   sample_valid  upstream offers a pair
//   sample_ready  holding register empty (pair accepted on valid & ready)
//   aud_xck       codec master clock (XCK_HALF clk cycles per half period)
//   aud_bclk      bit clock (BCLK_HALF clk cycles per half period)
//   aud_daclrck   0 = left slot, 1 = right slot
//   aud_dacdat    serial data, MSB first, changes when aud_bclk falls
//   underrun      sticky: a frame started with an empty holding register
//
// Build option WM8731_UNDERRUN_MUTE_EN: when defined an underrun frame is
// all zeros; otherwise the previously transmitted pair is repeated.

module wm8731_dac_tx #(
  parameter int XCK_HALF  = 2,
  parameter int BCLK_HALF = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_l,
  input  logic [15:0] sample_r,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        aud_xck,
  output logic        aud_bclk,
  output logic        aud_daclrck,
  output logic        aud_dacdat,
  output logic        underrun
);

  localparam int XW = (XCK_HALF > 1) ? $clog2(XCK_HALF) : 1;
  localparam int BW = $clog2(BCLK_HALF);

  logic [XW-1:0] xck_cnt;
  logic [BW-1:0] bclk_cnt;
  logic [4:0]    bit_idx;
  logic [4:0]    next_idx;
  logic [31:0]   shift;
  logic [31:0]   hold;
  logic          full;
  logic          fall;
  logic          frame_start;
  logic          accept;
  logic [31:0]   underrun_pat;
  logic [31:0]   frame_word;

  // A fall event is the cycle in which the registered bit clock goes 1 -> 0.
  assign fall        = (bclk_cnt == BW'(BCLK_HALF - 1)) && aud_bclk;
  assign frame_start = fall && (bit_idx == 5'd31);
  assign next_idx    = bit_idx + 5'd1;
  assign accept      = sample_valid && !full;
  assign sample_ready = !full;
  assign frame_word  = full ? hold : underrun_pat;

`ifdef WM8731_UNDERRUN_MUTE_EN
  assign underrun_pat = 32'h0000_0000;
`else
  // Remembers the pair loaded at the last frame start so it can be repeated.
  logic [31:0] last_pair;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_pair <= 32'h0000_0000;
    end else if (frame_start) begin
      last_pair <= frame_word;
    end
  end

  assign underrun_pat = last_pair;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      xck_cnt     <= '0;
      bclk_cnt    <= '0;
      bit_idx     <= 5'd31;
      shift       <= 32'h0000_0000;
      hold        <= 32'h0000_0000;
      full        <= 1'b0;
      aud_xck     <= 1'b0;
      aud_bclk    <= 1'b0;
      aud_daclrck <= 1'b0;
      aud_dacdat  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (xck_cnt == XW'(XCK_HALF - 1)) begin
        xck_cnt <= '0;
        aud_xck <= ~aud_xck;
      end else begin
        xck_cnt <= xck_cnt + 1'b1;
      end

      if (bclk_cnt == BW'(BCLK_HALF - 1)) begin
        bclk_cnt <= '0;
        aud_bclk <= ~aud_bclk;
      end else begin
        bclk_cnt <= bclk_cnt + 1'b1;
      end

      if (fall) begin
        bit_idx <= next_idx;
        if (frame_start) begin
          shift       <= frame_word;
          aud_dacdat  <= frame_word[31];
          aud_daclrck <= 1'b0;
          full        <= 1'b0;
          if (!full) begin
            underrun <= 1'b1;
          end
        end else begin
          shift       <= {shift[30:0], 1'b0};
          aud_dacdat  <= shift[30];
          aud_daclrck <= next_idx[4];
        end
      end

      // An accept only happens with holding empty, so it never collides with
      // a frame start consuming a full register; a pair accepted in the
      // frame-start cycle waits for the next frame.
      if (accept) begin
        hold <= {sample_l, sample_r};
        full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wm8731_dac_tx.sv
// tb/tb_wm8731_dac_tx.sv - self-checking bench for wm8731_dac_tx

module tb_wm8731_dac_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_valid;
  logic        sample_ready;
  logic        aud_xck;
  logic        aud_bclk;
  logic        aud_daclrck;
  logic        aud_dacdat;
  logic        underrun;

  wm8731_dac_tx dut (
    .clk          (clk),
    .reset        (reset),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .aud_xck      (aud_xck),
    .aud_bclk     (aud_bclk),
    .aud_daclrck  (aud_daclrck),
    .aud_dacdat   (aud_dacdat),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: k counts clk edges since reset release; frames start at
  // edge 32 + 1024*j, bit b of a frame is on the pins from edge 32+1024*j+32*b.
  int          k;
  logic        m_full;
  logic [31:0] m_hold;
  logic [31:0] m_cur;
  logic        m_und;
  logic [31:0] cap;
  logic [31:0] frame_cap;
  int          dut_acc;

  typedef struct {
    int   k;
    logic bclk;
    logic xck;
    logic lrck;
    logic dat;
  } tv_t;
  tv_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at k=%0d: actual=%h required=%h", name, k, act, exp);
    end
  endtask

  function automatic logic [31:0] upat();
`ifdef WM8731_UNDERRUN_MUTE_EN
    return 32'h0;
`else
    return m_cur;
`endif
  endfunction

  function automatic int next_fs(input int kk);
    if (kk < 32) return 32;
    return 32 + ((kk - 32) / 1024 + 1) * 1024;
  endfunction

  task automatic model_edge();
    logic acc;
    acc = sample_valid && !m_full;
    if (reset) begin
      k = 0; m_full = 0; m_hold = 0; m_cur = 0; m_und = 0;
    end else begin
      k++;
      if (k >= 32 && (k - 32) % 1024 == 0) begin
        if (m_full) m_cur = m_hold;
        else begin
          m_und = 1'b1;
          m_cur = upat();
        end
        m_full = 1'b0;
      end
      if (acc) begin
        m_hold = {sample_l, sample_r};
        m_full = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    int   bi;
    logic e_l;
    logic e_d;
    if (k < 32) begin
      e_l = 1'b0; e_d = 1'b0;
    end else begin
      bi  = ((k - 32) / 32) % 32;
      e_l = (bi >= 16);
      e_d = m_cur[31 - bi];
    end
    chk("xck",     32'(aud_xck),      32'((k / 2) % 2));
    chk("bclk",    32'(aud_bclk),     32'((k / 16) % 2));
    chk("daclrck", 32'(aud_daclrck),  32'(e_l));
    chk("dacdat",  32'(aud_dacdat),   32'(e_d));
    chk("ready",   32'(sample_ready), 32'(!m_full));
    chk("underrun",32'(underrun),     32'(m_und));
    if (!reset && k >= 48 && (k - 48) % 32 == 0) begin
      cap = {cap[30:0], aud_dacdat};
      if (((k - 48) / 32) % 32 == 31) frame_cap = cap;
    end
  endtask

  task automatic step();
    if (sample_valid && sample_ready && !reset) dut_acc++;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run_to(input int target);
    for (int n = 0; n < 5000 && k < target; n++) step();
    if (k < target) begin
      vectors++; miscompares++;
      $display("FAIL run_to timeout: actual k=%0d required k=%0d", k, target);
    end
  endtask

  task automatic offer(input logic [15:0] l, input logic [15:0] r);
    logic acc;
    logic ok;
    ok = 1'b0;
    sample_l = l; sample_r = r; sample_valid = 1'b1;
    for (int n = 0; n < 2100; n++) begin
      acc = !m_full;
      step();
      if (acc) begin ok = 1'b1; break; end
    end
    sample_valid = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL offer timeout: actual accepted=0 required accepted=1");
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int fs1;
    int fs2;
    tbl[0]  = '{2,    1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{4,    1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{15,   1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{16,   1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{31,   1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{32,   1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{48,   1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{64,   1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{543,  1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{544,  1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1040, 1'b1, 1'b0, 1'b1, 1'b0};

    k = 0; m_full = 0; m_hold = 0; m_cur = 0; m_und = 0;
    cap = 0; frame_cap = 0; dut_acc = 0;
    sample_l = 16'h0; sample_r = 16'h0; sample_valid = 1'b0;

    // Reset state
    reset = 1'b1;
    repeat (3) step();
    chk("rst_ready",    32'(sample_ready), 32'd1);
    chk("rst_underrun", 32'(underrun),     32'd0);
    chk("rst_bclk",     32'(aud_bclk),     32'd0);
    chk("rst_dacdat",   32'(aud_dacdat),   32'd0);
    reset = 1'b0;

    // First frame: A5A5/5A5A accepted on edge 1, clock/slot timing table
    offer(16'hA5A5, 16'h5A5A);
    for (int i = 0; i < 11; i++) begin
      run_to(tbl[i].k);
      chk("tbl_bclk", 32'(aud_bclk),    32'(tbl[i].bclk));
      chk("tbl_xck",  32'(aud_xck),     32'(tbl[i].xck));
      chk("tbl_lrck", 32'(aud_daclrck), 32'(tbl[i].lrck));
      chk("tbl_dat",  32'(aud_dacdat),  32'(tbl[i].dat));
    end
    offer(16'h1234, 16'hFEDC);
    run_to(1041);
    chk("frame1_word", frame_cap, 32'hA5A55A5A);
    chk("frame1_underrun", 32'(underrun), 32'd0);
    run_to(2065);
    chk("frame2_word", frame_cap, 32'h1234FEDC);
    chk("frame2_underrun", 32'(underrun), 32'd0);

    // Continuous valid: one pair per 1024 cycles
    sample_valid = 1'b1;
    for (int n = 0; n < 1100 && ((k - 32) % 1024) != 5; n++) begin
      sample_l = 16'($urandom); sample_r = 16'($urandom);
      step();
    end
    dut_acc = 0;
    for (int n = 0; n < 3072; n++) begin
      sample_l = 16'($urandom); sample_r = 16'($urandom);
      step();
    end
    chk("accepts_per_3072", 32'(dut_acc), 32'd3);
    sample_valid = 1'b0;

    // Starvation after 7FFF/8001
    offer(16'h7FFF, 16'h8001);
    fs1 = next_fs(k);
    fs2 = fs1 + 1024;
    run_to(fs1 + 1009);
    chk("last_pair_word", frame_cap, 32'h7FFF8001);
    run_to(fs2 + 1009);
`ifdef WM8731_UNDERRUN_MUTE_EN
    chk("underrun_word", frame_cap, 32'h00000000);
`else
    chk("underrun_word", frame_cap, 32'h7FFF8001);
`endif
    chk("underrun_flag", 32'(underrun), 32'd1);

    // Accept in the exact frame-start cycle with holding empty
    do_reset();
    run_to(31);
    sample_l = 16'h0F0F; sample_r = 16'hF00F; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    chk("fs_accept_underrun", 32'(underrun), 32'd1);
    chk("fs_accept_ready", 32'(sample_ready), 32'd0);
    run_to(32 + 1009);
    chk("fs_accept_frame0", frame_cap, 32'h00000000);
    run_to(1056 + 1009);
    chk("fs_accept_frame1", frame_cap, 32'h0F0FF00F);

    // Reset at bit index 20 with a pair pending
    run_to(2085);
    offer(16'hDEAD, 16'hBEEF);
    run_to(2080 + 20 * 32 + 3);
    reset = 1'b1;
    step();
    chk("midrst_ready",    32'(sample_ready), 32'd1);
    chk("midrst_underrun", 32'(underrun),     32'd0);
    chk("midrst_dacdat",   32'(aud_dacdat),   32'd0);
    chk("midrst_lrck",     32'(aud_daclrck),  32'd0);
    chk("midrst_bclk",     32'(aud_bclk),     32'd0);
    reset = 1'b0;
    run_to(1041);
    chk("midrst_frame0", frame_cap, 32'h00000000);
    run_to(2065);
    chk("midrst_frame1", frame_cap, 32'h00000000);

    // Randomized traffic against the model
    for (int n = 0; n < 4096; n++) begin
      sample_valid = ($urandom_range(0, 1499) == 0);
      sample_l = 16'($urandom); sample_r = 16'($urandom);
      step();
    end
    sample_valid = 1'b0;
    for (int n = 0; n < 4096; n++) begin
      sample_valid = ($urandom_range(0, 3) == 0);
      sample_l = 16'($urandom); sample_r = 16'($urandom);
      step();
    end
    sample_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
